subdiv_stage_scheduler: RTL
===========================

// Module: subdiv_stage_scheduler
// PURPOSE
//  Sequences the subdivision pipeline: neighbor-list build (stage 0), then smoothing (stage 1).
//  Each stage is launched over its start/busy handshake.
//  Owns the single port of the shared neighbor RAM and grants it to host, stage 0 or stage 1 by phase.
//  Reports completion, a handshake-timeout error and per-stage cycle counts.
// PARAMETERS
//  ADDR_WIDTH   9   shared RAM address width
//  ACK_TIMEOUT  16  max cycles from stage start pulse to stage busy rising
//  CNT_WIDTH    24  width of per-stage cycle counters (saturating)
// PORTS
//  clk          in   1             system clock, all logic on posedge
//  rst          in   1             asynchronous, active-high reset
//  go           in   1             host request to run both stages
//  done         out  1             1-cycle pulse when stage 1 finishes
//  err          out  1             sticky handshake-timeout flag, cleared by next accepted go
//  busy         out  1             high in every state except IDLE
//  stg_start    out  2             per-stage 1-cycle start pulse; bit0=neighbor, bit1=smooth
//  stg_busy     in   2             per-stage busy; same clk domain
//  s0_cycles    out  CNT_WIDTH     cycles stage 0 spent busy, held after run
//  s1_cycles    out  CNT_WIDTH     cycles stage 1 spent busy, held after run
//  req_en       in   3             RAM EN per requester; idx0=host, 1=stage0, 2=stage1
//  req_we       in   3*4           byte WE per requester, packed {s1,s0,host}
//  req_a        in   3*ADDR_WIDTH  address per requester, packed
//  req_di       in   3*32          write data per requester, packed
//  ram_en       out  1             to RAM: EN of granted requester
//  ram_we       out  4             to RAM: WE of granted requester
//  ram_a        out  ADDR_WIDTH    to RAM: address of granted requester
//  ram_di       out  32            to RAM: write data of granted requester
//  ram_do       in   32            RAM read data, fanned out unchanged to all requesters externally
//  grant        out  2             current owner: 0=host, 1=stage0, 2=stage1
// BEHAVIOUR
//  Reset values: state IDLE, grant 0, stg_start 0, done 0, err 0, busy 0, counters 0.
//   Asserting rst mid-run abandons the run immediately; no start pulse is reissued.
//  States and transitions:
//   IDLE:    grant host. On go: clear err and counters, pulse stg_start[0], enter S0_ACK.
//   S0_ACK:  grant stage0; count cycles since the pulse.
//            stg_busy[0]=1 -> S0_RUN. Count reaches ACK_TIMEOUT -> ERR.
//   S0_RUN:  s0_cycles++ each cycle. stg_busy[0]=0 -> pulse stg_start[1], enter S1_ACK.
//   S1_ACK / S1_RUN: same as the stage 0 pair, using index 1 and s1_cycles.
//            Busy falling in S1_RUN -> DONE.
//   DONE:    done=1 for exactly one cycle, grant host, then IDLE.
//   ERR:     err=1, stg_start=0, grant host, then IDLE. err stays set.
//  Handshake:
//   - start pulse is registered, exactly 1 cycle.
//   - Busy sampled the cycle after the pulse counts as an ack.
//   - A stage whose busy is already high at the start pulse is acked on the next cycle.
//  go is ignored while busy=1; a go coincident with rst is dropped.
//  Arbitration:
//   - grant is registered; it changes only on state transitions.
//   - RAM mux is combinational from grant.
//   - Non-granted requester signals are ignored: writes dropped, no EN forwarded.
//   - Stage 1 is granted in the same cycle its start pulse is issued, so it may access
//     the RAM from its first active edge.
//  Counters saturate at all-ones and never wrap.
//   Counter = ACK cycles excluded + RUN cycles.
// TESTING
//  Nominal: go; stage0 busy 2 cyc after start for 40 cyc; stage1 busy 1 cyc after for 25 cyc
//   -> s0_cycles=40, s1_cycles=25, single done pulse, err=0.
//  Timeout: go; stage0 never raises busy
//   -> err=1 exactly 16 cyc after stg_start[0]; stg_start[1] never pulses; state IDLE.
//  Arbitration: host writes A=0x05 D=0xAA while stage0 granted
//   -> ram_we=0 for the host write; stage0 write A=0x0A passes through unchanged.
//  Go during run: second go pulse during S0_RUN
//   -> ignored; exactly one done; counters unaffected.
//  Reset mid-run: rst asserted during S1_RUN
//   -> immediately grant=0, busy=0, stg_start=0, no done.
//  Saturation: CNT_WIDTH=4, stage0 busy 20 cyc -> s0_cycles=15.

Source files
------------

// File: rtl/subdiv_stage_scheduler.sv
// Two-stage subdivision sequencer: launches neighbor build then smoothing over a
// start/busy handshake, arbitrates the shared neighbor RAM and counts busy cycles.
module subdiv_stage_scheduler #(
    parameter int ADDR_WIDTH  = 9,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    output logic                    done,
    output logic                    err,
    output logic                    busy,
    output logic [1:0]              stg_start,
    input  logic [1:0]              stg_busy,
    output logic [CNT_WIDTH-1:0]    s0_cycles,
    output logic [CNT_WIDTH-1:0]    s1_cycles,
    input  logic [2:0]              req_en,
    input  logic [3*4-1:0]          req_we,
    input  logic [3*ADDR_WIDTH-1:0] req_a,
    input  logic [3*32-1:0]         req_di,
    output logic                    ram_en,
    output logic [3:0]              ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_a,
    output logic [31:0]             ram_di,
    input  logic [31:0]             ram_do,
    output logic [1:0]              grant
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_S0_ACK = 3'd1;
    localparam logic [2:0] ST_S0_RUN = 3'd2;
    localparam logic [2:0] ST_S1_ACK = 3'd3;
    localparam logic [2:0] ST_S1_RUN = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    localparam logic [1:0] GRANT_HOST = 2'd0;
    localparam logic [1:0] GRANT_S0   = 2'd1;
    localparam logic [1:0] GRANT_S1   = 2'd2;

    localparam int              TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]   ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0]   ACK_ONE  = TW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    start_q, start_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [TW-1:0] ack_cnt_q, ack_cnt_d;
    logic          clr_cnt;
    logic [1:0]    inc_cnt;

    // Read data goes straight to the requesters outside this block.
    logic unused_ram_do;
    assign unused_ram_do = ^ram_do;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        start_d   = 2'b00;
        done_d    = 1'b0;
        err_d     = err_q;
        ack_cnt_d = ack_cnt_q;
        clr_cnt   = 1'b0;
        inc_cnt   = 2'b00;
        case (state_q)
            ST_IDLE: begin
                grant_d = GRANT_HOST;
                if (go) begin
                    err_d     = 1'b0;
                    clr_cnt   = 1'b1;
                    start_d   = 2'b01;
                    ack_cnt_d = '0;
                    grant_d   = GRANT_S0;
                    state_d   = ST_S0_ACK;
                end
            end
            ST_S0_ACK: begin
                // The acknowledging cycle is itself a busy cycle and is counted.
                if (stg_busy[0]) begin
                    inc_cnt[0] = 1'b1;
                    state_d    = ST_S0_RUN;
                end else if (ack_cnt_q == ACK_LAST) begin
                    err_d   = 1'b1;
                    grant_d = GRANT_HOST;
                    state_d = ST_ERR;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_ONE;
                end
            end
            ST_S0_RUN: begin
                if (stg_busy[0]) begin
                    inc_cnt[0] = 1'b1;
                end else begin
                    start_d   = 2'b10;
                    ack_cnt_d = '0;
                    grant_d   = GRANT_S1;
                    state_d   = ST_S1_ACK;
                end
            end
            ST_S1_ACK: begin
                if (stg_busy[1]) begin
                    inc_cnt[1] = 1'b1;
                    state_d    = ST_S1_RUN;
                end else if (ack_cnt_q == ACK_LAST) begin
                    err_d   = 1'b1;
                    grant_d = GRANT_HOST;
                    state_d = ST_ERR;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_ONE;
                end
            end
            ST_S1_RUN: begin
                if (stg_busy[1]) begin
                    inc_cnt[1] = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    grant_d = GRANT_HOST;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: begin
                grant_d = GRANT_HOST;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= GRANT_HOST;
            start_q   <= 2'b00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            start_q   <= start_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cyc_q, cyc_d;

            always_comb begin
                cyc_d = cyc_q;
                if (clr_cnt) begin
                    cyc_d = '0;
                end else if (inc_cnt[gi] && (cyc_q != '1)) begin
                    cyc_d = cyc_q + CNT_ONE;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cyc_q <= '0;
                end else begin
                    cyc_q <= cyc_d;
                end
            end
        end
    endgenerate

    assign s0_cycles = g_cnt[0].cyc_q;
    assign s1_cycles = g_cnt[1].cyc_q;

    logic [3:0]            we_arr [3];
    logic [ADDR_WIDTH-1:0] a_arr  [3];
    logic [31:0]           di_arr [3];

    generate
        for (gi = 0; gi < 3; gi++) begin : g_req
            assign we_arr[gi] = req_we[gi*4 +: 4];
            assign a_arr[gi]  = req_a[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign di_arr[gi] = req_di[gi*32 +: 32];
        end
    endgenerate

    // Only the owner reaches the RAM; everyone else is silenced entirely.
    always_comb begin
        ram_en = 1'b0;
        ram_we = 4'h0;
        ram_a  = '0;
        ram_di = 32'h0;
        case (grant_q)
            GRANT_HOST, GRANT_S0, GRANT_S1: begin
                ram_en = req_en[grant_q];
                ram_we = we_arr[grant_q];
                ram_a  = a_arr[grant_q];
                ram_di = di_arr[grant_q];
            end
            default: ;
        endcase
    end

    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);
    assign stg_start = start_q;
    assign grant     = grant_q;

endmodule
